// File: rtl/mux_arb_reg.sv
// Registered N-channel selector with valid/ready handshakes on every input and a
// single-entry output register with backpressure. The selection policy is fixed at
// elaboration: external select, fixed priority or round-robin.
module mux_arb_reg #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned NCH   = 3,
    parameter int unsigned MODE  = 0,
    localparam int unsigned SELW = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NCH*WIDTH-1:0]   in_data,
    input  logic [NCH-1:0]         in_valid,
    output logic [NCH-1:0]         in_ready,
    input  logic [SELW-1:0]        sel,
    output logic [WIDTH-1:0]       out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [SELW-1:0]        out_ch
);

    logic             load;
    logic             grant_valid;
    logic [SELW-1:0]  g;
    logic [SELW-1:0]  ptr_q;
    logic [SELW-1:0]  next_ptr;
    logic [WIDTH-1:0] chan [NCH];

    // The register accepts a word when empty or when its current word leaves this cycle.
    assign load = !out_valid || out_ready;

    // Unpack the flat input bus into one word per channel.
    always_comb begin
        for (int i = 0; i < int'(NCH); i++) begin
            chan[i] = in_data[i*WIDTH +: WIDTH];
        end
    end

    // Arbitration: pick the granted channel according to the elaborated policy.
    always_comb begin
        int idx;
        grant_valid = 1'b0;
        g           = '0;
        idx         = 0;
        if (MODE == 0) begin
            // An out-of-range select grants nothing.
            if (int'(sel) < int'(NCH)) begin
                grant_valid = in_valid[sel];
                g           = sel;
            end
        end else if (MODE == 2) begin
            // Walk downward so the last hit is the first valid channel at or after ptr.
            for (int k = int'(NCH) - 1; k >= 0; k--) begin
                idx = int'(ptr_q) + k;
                if (idx >= int'(NCH)) begin
                    idx = idx - int'(NCH);
                end
                if (in_valid[SELW'(idx)]) begin
                    grant_valid = 1'b1;
                    g           = SELW'(idx);
                end
            end
        end else begin
            // Fixed priority; also the fallback for any unsupported MODE value.
            for (int i = int'(NCH) - 1; i >= 0; i--) begin
                if (in_valid[SELW'(i)]) begin
                    grant_valid = 1'b1;
                    g           = SELW'(i);
                end
            end
        end
    end

    // Round-robin pointer advances to the channel after the one just served.
    always_comb begin
        if (int'(g) == int'(NCH) - 1) begin
            next_ptr = '0;
        end else begin
            next_ptr = g + SELW'(1);
        end
    end

    // One-hot handshake back to the granted producer; nothing is taken during reset.
    always_comb begin
        in_ready = '0;
        if (!rst && load && grant_valid) begin
            in_ready[g] = 1'b1;
        end
    end

    // Output register: load on transfer, clear valid on drain, hold on stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            ptr_q     <= '0;
        end else if (load) begin
            if (grant_valid) begin
                out_valid <= 1'b1;
                out_data  <= chan[g];
                out_ch    <= g;
                ptr_q     <= next_ptr;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/mux_arb_reg.md
Name: mux_arb_reg

Overview:
- Registered N-channel datapath selector for the RISC-V core. It is the parametrised successor of the three-input combinational multiplexer.
- Adds per-channel valid/ready handshakes, three selection modes (external select, fixed priority, round-robin) and a single-entry output register with backpressure.
- Used where several producers share one consumer, e.g. writeback-source or memory-request selection, where a combinational select would create timing or contention problems.

Parameters:
- WIDTH, 32, data width of every channel and of the output.
- NCH, 3, number of input channels, legal range 2..16.
- MODE, 0, selection policy: 0 = external select, 1 = fixed priority (lowest index wins), 2 = round-robin.
- SELW, derived as clog2(NCH) with a minimum of 1; not user-set. Width of sel and out_ch.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- in_data  input  NCH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  NCH  channel i offers a word.
- in_ready  output  NCH  channel i word is taken this cycle.
- sel  input  SELW  channel index; used only when MODE=0.
- out_data  output  WIDTH  registered selected word.
- out_valid  output  1  out_data holds a word.
- out_ready  input  1  consumer accepts out_data.
- out_ch  output  SELW  index of the channel that supplied out_data.

Behaviour:
- Reset (rst=1 at posedge): out_valid=0, out_data=0, out_ch=0, round-robin pointer=0. in_ready is all-zero while rst=1.
- Reset mid-transfer: the held word is dropped. No channel is granted in the reset cycle.
- load = !out_valid || out_ready (combinational). The register can load in the same cycle it is drained, giving full throughput.
- Grant g is computed combinationally each cycle. in_ready[i] = load && grant_valid && (g==i). At most one in_ready bit is high; it never depends on in_valid[i] of the same channel except through arbitration.
- MODE 0: grant_valid = (sel < NCH) && in_valid[sel]; g = sel. An out-of-range sel grants nothing; out_valid follows the drain rule below.
- MODE 1: g = lowest i with in_valid[i]=1. grant_valid = |in_valid.
- MODE 2: g = first i with in_valid[i]=1, searching from ptr upward with wrap-around modulo NCH.
  - ptr <= (g+1) mod NCH only on a cycle where a transfer occurs (load && grant_valid).
  - Otherwise ptr holds.
- Transfer (load && grant_valid at posedge): out_data <= in_data[g], out_ch <= g, out_valid <= 1. Latency is one cycle from input handshake to out_valid.
- Drain without refill (out_valid && out_ready && !grant_valid): out_valid <= 0. out_data and out_ch hold their last values.
- Stall (out_valid && !out_ready): out_data, out_ch, out_valid and ptr all hold. in_ready is all-zero.
- Simultaneous drain and refill: new word loads. out_valid stays 1 with no bubble.
- Producer rule: a channel may change in_data/in_valid freely while not granted. No data is duplicated or lost.
- MODE is elaboration-time. An illegal MODE value behaves as MODE 1.

Test Plan:
- Reset and MODE 0 (WIDTH=32, NCH=3): hold rst for 2 cycles, then release. Expect out_valid=0, out_data=0, in_ready=000. Next: sel=1, in_valid=010, data1=0xA5A5_0001, out_ready=1. Expect in_ready=010 the same cycle; one cycle later out_valid=1, out_data=0xA5A5_0001, out_ch=1.
- MODE 0 out-of-range select: sel=3, in_valid=111. Expect in_ready=000. out_valid drops to 0 after draining the held word.
- MODE 1 priority: in_valid=110 with data1=0x11 and data2=0x22, held for 2 cycles with out_ready=1. Expect out_data=0x11 (out_ch=1) on both cycles; channel 2 is starved.
- MODE 2 round-robin: all in_valid=1, out_ready=1, 6 cycles. Expect out_ch sequence 0,1,2,0,1,2. With in_valid=101 from ptr=1, expect the next grant on ch2, then ch0.
- Backpressure: out_ready=0 for 3 cycles with out_valid=1 and out_data=0xDEAD_BEEF. Expect in_ready=000 and out_data stable. Then out_ready=1 with ch0 valid: the new word appears next cycle and out_valid never drops.
- Reset mid-operation: assert rst while out_valid=1 and out_ready=0. Next cycle out_valid=0 and out_data=0. In MODE 2, ptr=0, so the first grant after reset with in_valid=111 is ch0.
